// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bus controller: memory/IO decode, LED and 7-segment registers,
// switch/button synchronisers, UART TX FIFO and single-byte RX holding register.
module io_bus_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int N_LED    = 16,
  parameter int N_SW     = 16,
  parameter int N_BTN    = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_enable,
  input  logic              r_enable,
  input  logic [3:0]        cs_in,
  input  logic [31:0]       data_in,
  output logic              stall,
  output logic              w_enable_mem,
  output logic [3:0]        cs_mem,
  output logic              io_rvalid,
  output logic [31:0]       io_rdata,
  output logic [N_LED-1:0]  leds,
  output logic [31:0]       seg7,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OFF_UART_DATA = 6'h20;
  localparam logic [5:0] OFF_UART_STAT = 6'h21;
  localparam logic [5:0] OFF_LEDS      = 6'h30;
  localparam logic [5:0] OFF_SW        = 6'h31;
  localparam logic [5:0] OFF_BTN       = 6'h32;
  localparam logic [5:0] OFF_SEG7      = 6'h33;

  logic          io;
  logic [5:0]    offset;
  logic          io_wr, io_rd;
  logic          push, pop;
  logic          rd_rx, rd_stat, rd_btn;
  logic          tx_full, tx_empty;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [7:0]    rx_hold;
  logic          rx_full, rx_overrun;
  logic [N_SW-1:0]  sw_meta, sw_sync;
  logic [N_BTN-1:0] btn_meta, btn_sync, btn_prev, sticky;
  logic [31:0]   rd_data;

  assign io     = addr[ADDR_W-1];
  assign offset = addr[5:0];

  assign tx_full  = (cnt == CW'(TX_DEPTH));
  assign tx_empty = (cnt == '0);
  assign stall    = w_enable && io && (offset == OFF_UART_DATA) && tx_full;

  // A simultaneous write wins over the read; a stalled write does nothing.
  assign io_wr   = w_enable && !stall && io;
  assign io_rd   = r_enable && !w_enable && io;
  assign push    = io_wr && (offset == OFF_UART_DATA);
  assign pop     = tx_valid && tx_ready;
  assign rd_rx   = io_rd && (offset == OFF_UART_DATA);
  assign rd_stat = io_rd && (offset == OFF_UART_STAT);
  assign rd_btn  = io_rd && (offset == OFF_BTN);

  assign w_enable_mem = w_enable && !io;
  assign cs_mem       = io ? 4'b0000 : cs_in;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // NOTE: the FIFO storage has no reset; cnt alone decides what is visible,
  // which keeps the array mappable onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // A byte arriving while the old one is being read is captured, not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold    <= '0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_valid && (!rx_full || rd_rx)) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
      if (rx_valid && rx_full && !rd_rx) rx_overrun <= 1'b1;
      else if (rd_stat)                  rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      sticky   <= '0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      sticky   <= (rd_btn ? '0 : sticky) | (btn_sync & ~btn_prev);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
      seg7 <= '0;
    end else begin
      if (io_wr && offset == OFF_LEDS)
        for (int i = 0; i < N_LED; i++)
          if (cs_in[i/8]) leds[i] <= data_in[i];
      if (io_wr && offset == OFF_SEG7)
        for (int i = 0; i < 32; i++)
          if (cs_in[i/8]) seg7[i] <= data_in[i];
    end
  end

  // NOTE: rd_data gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_UART_DATA: rd_data[7:0]        = rx_hold;
      OFF_UART_STAT: rd_data[4+CW-1:0]   = {cnt, rx_overrun, rx_full, tx_empty, tx_full};
      OFF_LEDS:      rd_data[N_LED-1:0]  = leds;
      OFF_SW:        rd_data[N_SW-1:0]   = sw_sync;
      OFF_BTN: begin
        rd_data[16 +: N_BTN] = sticky;
        rd_data[N_BTN-1:0]   = btn_sync;
      end
      OFF_SEG7:      rd_data             = seg7;
      default:       rd_data             = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rvalid <= 1'b0;
      io_rdata  <= '0;
    end else begin
      io_rvalid <= io_rd;
      if (io_rd) io_rdata <= rd_data;
    end
  end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: reads push expected data, a negedge monitor
// pops and compares whenever io_rvalid is seen.
module tb_io_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  addr = '0;
  logic        w_enable = 1'b0, r_enable = 1'b0;
  logic [3:0]  cs_in = '0;
  logic [31:0] data_in = '0;
  logic        stall, w_enable_mem, io_rvalid, tx_valid;
  logic [3:0]  cs_mem;
  logic [31:0] io_rdata, seg7;
  logic [15:0] leds;
  logic [15:0] sw_in = '0;
  logic [3:0]  btn_in = '0;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  io_bus_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .w_enable(w_enable), .r_enable(r_enable),
    .cs_in(cs_in), .data_in(data_in), .stall(stall), .w_enable_mem(w_enable_mem),
    .cs_mem(cs_mem), .io_rvalid(io_rvalid), .io_rdata(io_rdata), .leds(leds),
    .seg7(seg7), .sw_in(sw_in), .btn_in(btn_in), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && io_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got io_rdata %h with no read pending", io_rdata);
      end else begin
        check("io_rdata", io_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] cs);
    addr = a; data_in = d; cs_in = cs; w_enable = 1'b1;
    cyc();
    w_enable = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp);
    addr = a; r_enable = 1'b1;
    exp_q.push_back(exp);
    cyc();
    r_enable = 1'b0;
  endtask

  logic [7:0] tx_exp [4];

  initial begin
    tx_exp[0] = 8'h11; tx_exp[1] = 8'h22; tx_exp[2] = 8'h33; tx_exp[3] = 8'h44;

    // Asynchronous reset, checked before the first clock edge.
    #2 rst = 1'b1;
    #2;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_seg7", seg7, 32'h0);
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_rvalid", 32'(io_rvalid), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Memory pass-through, write and read; no io_rvalid may follow.
    addr = 6'h05; w_enable = 1'b1; cs_in = 4'b0011; #1;
    check("mem_we", 32'(w_enable_mem), 32'h1);
    check("mem_cs", 32'(cs_mem), 32'h3);
    cyc();
    w_enable = 1'b0; r_enable = 1'b1;
    cyc();
    r_enable = 1'b0;
    cyc();

    // LED byte write, with io access masking memory strobes.
    addr = 6'h30; data_in = 32'h0000_A5FF; cs_in = 4'b0010; w_enable = 1'b1; #1;
    check("io_we_mem", 32'(w_enable_mem), 32'h0);
    check("io_cs_mem", 32'(cs_mem), 32'h0);
    cyc();
    w_enable = 1'b0;
    check("leds_byte", 32'(leds), 32'h0000_A500);
    rd(6'h30, 32'h0000_A500);

    // SEG7 full then single-byte write.
    wr(6'h33, 32'h1234_5678, 4'b1111);
    wr(6'h33, 32'hFFFF_FFAB, 4'b0001);
    check("seg7", seg7, 32'h1234_56AB);
    rd(6'h33, 32'h1234_56AB);

    // Switches after two synchroniser stages; unmapped read; ignored STAT write.
    sw_in = 16'hBEEF;
    cyc(); cyc();
    rd(6'h31, 32'h0000_BEEF);
    rd(6'h25, 32'h0);
    wr(6'h21, 32'hFFFF_FFFF, 4'b1111);
    rd(6'h21, 32'h0000_0002);

    // TX fill, stall, drain.
    tx_ready = 1'b0;
    addr = 6'h20; data_in = 32'h11; cs_in = 4'b0001; w_enable = 1'b1; #1;
    check("tx_no_bypass", 32'(tx_valid), 32'h0);
    cyc();
    w_enable = 1'b0;
    check("tx_valid_rise", 32'(tx_valid), 32'h1);
    check("tx_head", 32'(tx_data), 32'h11);
    wr(6'h20, 32'h22, 4'b0001);
    wr(6'h20, 32'h33, 4'b0001);
    wr(6'h20, 32'h44, 4'b0001);
    rd(6'h21, 32'h0000_0041);
    addr = 6'h20; data_in = 32'h55; w_enable = 1'b1; #1;
    check("stall_full", 32'(stall), 32'h1);
    cyc();
    w_enable = 1'b0;
    rd(6'h21, 32'h0000_0041);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(tx_data), 32'(tx_exp[i]));
      cyc();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_valid), 32'h0);
    check("drain_data0", 32'(tx_data), 32'h0);

    // Push and pop in the same cycle keeps count and order.
    wr(6'h20, 32'h66, 4'b0001);
    tx_ready = 1'b1;
    wr(6'h20, 32'h77, 4'b0001);
    tx_ready = 1'b0;
    check("pushpop_head", 32'(tx_data), 32'h77);
    rd(6'h21, 32'h0000_0010);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("pushpop_empty", 32'(tx_valid), 32'h0);

    // RX overrun and clear-on-read.
    rx_valid = 1'b1; rx_data = 8'h5A; cyc();
    rx_data = 8'hC3; cyc();
    rx_valid = 1'b0;
    rd(6'h21, 32'h0000_000E);
    rd(6'h21, 32'h0000_0006);
    rd(6'h20, 32'h0000_005A);
    rd(6'h21, 32'h0000_0002);

    // Read DATA in the same cycle as a new byte: old byte returned, new captured.
    rx_valid = 1'b1; rx_data = 8'h11; cyc();
    rx_data = 8'h22;
    rd(6'h20, 32'h0000_0011);
    rx_valid = 1'b0;
    rd(6'h21, 32'h0000_0006);
    rd(6'h20, 32'h0000_0022);

    // Button sticky bit.
    btn_in = 4'b0100;
    repeat (3) cyc();
    btn_in = 4'b0000;
    repeat (4) cyc();
    rd(6'h32, 32'h0004_0000);
    rd(6'h32, 32'h0000_0000);

    // Simultaneous write and read: write lands, read produces nothing.
    addr = 6'h30; data_in = 32'h1234; cs_in = 4'b0011; w_enable = 1'b1; r_enable = 1'b1;
    cyc();
    w_enable = 1'b0; r_enable = 1'b0;
    check("wr_rd_leds", 32'(leds), 32'h0000_1234);
    cyc();

    // Asynchronous reset mid-transfer.
    wr(6'h30, 32'hFFFF, 4'b0011);
    wr(6'h20, 32'hA1, 4'b0001);
    wr(6'h20, 32'hA2, 4'b0001);
    rd(6'h30, 32'h0000_FFFF);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_tx_valid", 32'(tx_valid), 32'h0);
    check("arst_tx_data", 32'(tx_data), 32'h0);
    check("arst_rvalid", 32'(io_rvalid), 32'h0);
    check("arst_rdata", io_rdata, 32'h0);
    check("arst_seg7", seg7, 32'h0);
    cyc();
    rst = 1'b0;
    rd(6'h21, 32'h0000_0002);

    repeat (3) cyc();
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised memory-mapped I/O bus controller between the CPU load/store port, data memory and the board peripherals. Decodes each access to memory or I/O, owns the LED and 7-segment output registers, synchronises switches and buttons, buffers UART transmit bytes in a FIFO and holds received UART bytes. All I/O reads return registered data one cycle after the request. A full transmit FIFO produces a stall.

## Interface
- ADDR_W, 6: CPU address width (≥6); MSB=0 selects memory
- N_LED, 16: LED count (≤32)
- N_SW, 16: switch count (≤32)
- N_BTN, 4: button count (≤16)
- TX_DEPTH, 4: UART TX FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  CPU word address
- w_enable  in  1  CPU write request
- r_enable  in  1  CPU read request
- cs_in  in  4  byte-lane strobes, bit k = data_in[8k+7:8k]
- data_in  in  32  CPU write data
- stall  out  1  combinational; CPU must hold the access
- w_enable_mem  out  1  memory write enable
- cs_mem  out  4  memory byte strobes
- io_rvalid  out  1  registered; io_rdata valid this cycle
- io_rdata  out  32  registered I/O read data
- leds  out  N_LED  LED register
- seg7  out  32  7-segment register
- sw_in  in  N_SW  raw switches
- btn_in  in  N_BTN  raw buttons
- tx_valid  out  1  TX FIFO non-empty
- tx_data  out  8  TX FIFO head
- tx_ready  in  1  UART accepts head
- rx_valid  in  1  one-cycle received-byte strobe
- rx_data  in  8  received byte

## Operation
Address map. io = addr[ADDR_W-1]. Offset = addr[5:0]:
- io=0: memory. w_enable_mem=w_enable. cs_mem=cs_in. io_rvalid not asserted.
- 0x20 UART_DATA: a write pushes data_in[7:0]. A read returns {24'0, rx_hold} and clears rx_full.
- 0x21 UART_STAT: a read returns {cnt, rx_overrun, rx_full, tx_empty, tx_full} in bits [4+CW-1:0], where CW=$clog2(TX_DEPTH)+1. Reading it clears rx_overrun. Writes are ignored.
- 0x30 LEDS: read/write. A write updates only the strobed bytes within N_LED.
- 0x31 SW: read-only. Returns the synchronised switches, zero-extended.
- 0x32 BTN: read-only. Returns {sticky[N_BTN-1:0] in [31:16], level in [N_BTN-1:0]}. Reading it clears sticky.
- 0x33 SEG7: read/write, byte-strobed.
- Any other io offset: writes are ignored; reads return 0 with io_rvalid=1.
- For every io access, w_enable_mem=0 and cs_mem=0.

Registers and synchronisers:
- sw and btn pass through 2-FF synchronisers.
- sticky[i] is set on a rising edge of synchronised btn[i].
- TX FIFO:
  - Push happens on a write to UART_DATA when not full.
  - Pop happens when tx_valid && tx_ready.
  - Pointers wrap modulo TX_DEPTH.
  - cnt ranges 0..TX_DEPTH.
- RX: on rx_valid, if rx_full=0, capture into rx_hold and set rx_full. If rx_full=1, drop the byte and set rx_overrun.
- stall = w_enable && io && offset==0x20 && tx_full. This applies even if a pop occurs the same cycle. A stalled write has no side effect.
- If w_enable and r_enable are both set, the write takes effect and the read is ignored.

Boundary cases:
- Push and pop in the same cycle with 0<cnt<TX_DEPTH: cnt is unchanged and order is preserved.
- Push when empty: tx_valid rises the next cycle. Head is not bypassed.
- Read of UART_DATA in the same cycle as rx_valid: the read returns the old byte, the new byte is captured, and rx_full stays 1. No overrun.
- Read of BTN in the same cycle as a new edge on bit i: the read returns the old sticky value and sticky[i] stays 1.
- Read of STAT in the same cycle as a new overrun: the read returns the old flag and rx_overrun stays 1.

## Timing
- Reset: leds=0, seg7=0, io_rdata=0, io_rvalid=0, FIFO empty (tx_valid=0, tx_data=0), rx_hold=0, rx_full=0, rx_overrun=0, sticky=0, synchronisers=0.
- Reset mid-operation discards FIFO contents and pending RX immediately.
- Write latency: the register or FIFO updates at the clock edge of the accepted write.
- Read latency: io_rvalid/io_rdata appear 1 cycle after r_enable. io_rvalid is a one-cycle pulse per read cycle.
- Read-clear side effects apply at the same edge that registers io_rdata.
- Input latency: 2 cycles from sw_in/btn_in to the synchronised value. sticky is set 1 cycle later.
- tx_data/tx_valid are registered from FIFO state. tx_ready is sampled on clk.

## Test plan
- Memory pass-through: addr=0x05, w_enable=1, cs_in=4'b0011 -> w_enable_mem=1, cs_mem=4'b0011, io_rvalid stays 0.
- LED byte write: write 0x0000_A5FF with cs_in=4'b0010 to 0x30 after reset -> leds=16'hA500. Read 0x30 -> io_rdata=0x0000_A500 exactly one cycle later.
- TX fill and stall:
  - Setup: tx_ready=0, TX_DEPTH=4.
  - Push 0x11, 0x22, 0x33, 0x44 -> STAT cnt=4, tx_full=1.
  - Fifth write -> stall=1, no change.
  - Raise tx_ready for 4 cycles -> tx_data sequence 11,22,33,44. tx_valid falls after the fourth pop.
- RX overrun:
  - rx_valid with 0x5A, then 0xC3 before any read.
  - Read STAT -> rx_full=1, rx_overrun=1.
  - Read STAT again -> rx_overrun=0.
  - Read DATA -> 0x5A, rx_full=0.
- Button sticky: pulse btn_in[2] for 3 cycles and wait 4 cycles. Read 0x32 -> bit 18 = 1. Second read -> bit 18 = 0.
- Async reset mid-transfer: assert rst with FIFO cnt=2 and leds=0xFFFF -> all outputs reach reset values without a clock edge.
